// File: rtl/counter_csr_ctrl_pkg.sv
// Shared constants and types for the performance-counter CSR controller.
// Address map, inhibit bit positions and the access FSM state.
package counter_csr_pkg;

    localparam logic [11:0] ADDR_MCYCLE        = 12'hB00;
    localparam logic [11:0] ADDR_MCYCLEH       = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRET      = 12'hB02;
    localparam logic [11:0] ADDR_MINSTRETH     = 12'hB82;
    localparam logic [11:0] ADDR_CYCLE         = 12'hC00;
    localparam logic [11:0] ADDR_CYCLEH        = 12'hC80;
    localparam logic [11:0] ADDR_INSTRET       = 12'hC02;
    localparam logic [11:0] ADDR_INSTRETH      = 12'hC82;
    localparam logic [11:0] ADDR_MCOUNTINHIBIT = 12'h320;

    localparam int INH_CY = 0;
    localparam int INH_IR = 2;

    typedef enum logic {
        IDLE,
        RESP
    } state_t;

endpackage

// File: rtl/counter_csr_ctrl_if.sv
// CSR access bus between the pipeline CSR stage and the counter controller.
// master = pipeline side, slave = controller side.
interface counter_csr_ctrl_if;

    logic        CSR_REQ_IP;
    logic        CSR_WE_IP;
    logic [11:0] CSR_ADDR_IP;
    logic [31:0] CSR_WDATA_IP;
    logic        CSR_ACK_OP;
    logic [31:0] CSR_RDATA_OP;
    logic        CSR_ERR_OP;

    modport master (
        output CSR_REQ_IP, CSR_WE_IP, CSR_ADDR_IP, CSR_WDATA_IP,
        input  CSR_ACK_OP, CSR_RDATA_OP, CSR_ERR_OP
    );

    modport slave (
        input  CSR_REQ_IP, CSR_WE_IP, CSR_ADDR_IP, CSR_WDATA_IP,
        output CSR_ACK_OP, CSR_RDATA_OP, CSR_ERR_OP
    );

endinterface

// File: rtl/counter_csr_ctrl_counter64.sv
// One 64-bit counter with half-word writes and a high-half snapshot.
// A write to either half beats the increment on the same edge.
module counter64_unit (
    input  logic        CLK_IP,
    input  logic        RSTN_IP,
    input  logic        inc_en,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wdata,
    input  logic        snap_load,
    input  logic        snap_clr,
    output logic [63:0] cnt,
    output logic [31:0] snap,
    output logic        snap_vld
);

    always_ff @(posedge CLK_IP or negedge RSTN_IP) begin
        if (!RSTN_IP) begin
            cnt <= '0;
        end else if (wr_lo) begin
            cnt <= {cnt[63:32], wdata};
        end else if (wr_hi) begin
            cnt <= {wdata, cnt[31:0]};
        end else if (inc_en) begin
            cnt <= cnt + 64'd1;
        end
    end

    // Any write invalidates a pending snapshot so a stale high half never leaks
    always_ff @(posedge CLK_IP or negedge RSTN_IP) begin
        if (!RSTN_IP) begin
            snap     <= '0;
            snap_vld <= 1'b0;
        end else if (wr_lo || wr_hi) begin
            snap_vld <= 1'b0;
        end else if (snap_load) begin
            snap     <= cnt[63:32];
            snap_vld <= 1'b1;
        end else if (snap_clr) begin
            snap_vld <= 1'b0;
        end
    end

endmodule

// File: rtl/counter_csr_ctrl.sv
// CSR-side controller for the cycle/instret counters and mcountinhibit.
// One access per two cycles: accept in IDLE, ACK during RESP.
module counter_csr_ctrl
    import counter_csr_pkg::*;
#(
    parameter logic [2:0] INHIBIT_RST = 3'b000,
    parameter bit         SNAPSHOT_EN = 1'b1
) (
    input  logic                 CLK_IP,
    input  logic                 RSTN_IP,
    input  logic                 RETIRE_IP,
    counter_csr_ctrl_if.slave    csr
);

    state_t      state;
    logic [2:0]  inhibit;
    logic        ack;
    logic [31:0] rdata;
    logic        err;

    logic        accept;
    logic        we;
    logic [11:0] addr;
    logic        ro;
    logic [31:0] rd_val;
    logic        err_c;
    logic        inh_wr;

    logic        cy_wr_lo, cy_wr_hi, cy_load, cy_clr, cy_vld;
    logic        ir_wr_lo, ir_wr_hi, ir_load, ir_clr, ir_vld;
    logic [63:0] cy_cnt, ir_cnt;
    logic [31:0] cy_snap, ir_snap;

    assign accept = (state == IDLE) && csr.CSR_REQ_IP;
    assign we     = csr.CSR_WE_IP;
    assign addr   = csr.CSR_ADDR_IP;
    assign ro     = (addr[11:8] == 4'hC);

    always_comb begin
        rd_val   = '0;
        err_c    = 1'b0;
        inh_wr   = 1'b0;
        cy_wr_lo = 1'b0;
        cy_wr_hi = 1'b0;
        cy_load  = 1'b0;
        cy_clr   = 1'b0;
        ir_wr_lo = 1'b0;
        ir_wr_hi = 1'b0;
        ir_load  = 1'b0;
        ir_clr   = 1'b0;
        unique case (1'b1)
            (addr == ADDR_MCYCLE) || (addr == ADDR_CYCLE): begin
                rd_val   = cy_cnt[31:0];
                cy_load  = !we && SNAPSHOT_EN;
                cy_wr_lo = we && !ro;
            end
            (addr == ADDR_MCYCLEH) || (addr == ADDR_CYCLEH): begin
                rd_val   = (SNAPSHOT_EN && cy_vld) ? cy_snap : cy_cnt[63:32];
                cy_clr   = !we;
                cy_wr_hi = we && !ro;
            end
            (addr == ADDR_MINSTRET) || (addr == ADDR_INSTRET): begin
                rd_val   = ir_cnt[31:0];
                ir_load  = !we && SNAPSHOT_EN;
                ir_wr_lo = we && !ro;
            end
            (addr == ADDR_MINSTRETH) || (addr == ADDR_INSTRETH): begin
                rd_val   = (SNAPSHOT_EN && ir_vld) ? ir_snap : ir_cnt[63:32];
                ir_clr   = !we;
                ir_wr_hi = we && !ro;
            end
            (addr == ADDR_MCOUNTINHIBIT): begin
                rd_val = {29'b0, inhibit};
                inh_wr = we;
            end
            default: begin
                err_c = 1'b1;
            end
        endcase
        if (we && ro) begin
            err_c = 1'b1;
        end
        if (we || err_c) begin
            rd_val = '0;
        end
    end

    counter64_unit u_cycle (
        .CLK_IP    (CLK_IP),
        .RSTN_IP   (RSTN_IP),
        .inc_en    (!inhibit[INH_CY]),
        .wr_lo     (accept && cy_wr_lo),
        .wr_hi     (accept && cy_wr_hi),
        .wdata     (csr.CSR_WDATA_IP),
        .snap_load (accept && cy_load),
        .snap_clr  (accept && cy_clr),
        .cnt       (cy_cnt),
        .snap      (cy_snap),
        .snap_vld  (cy_vld)
    );

    counter64_unit u_instret (
        .CLK_IP    (CLK_IP),
        .RSTN_IP   (RSTN_IP),
        .inc_en    (RETIRE_IP && !inhibit[INH_IR]),
        .wr_lo     (accept && ir_wr_lo),
        .wr_hi     (accept && ir_wr_hi),
        .wdata     (csr.CSR_WDATA_IP),
        .snap_load (accept && ir_load),
        .snap_clr  (accept && ir_clr),
        .cnt       (ir_cnt),
        .snap      (ir_snap),
        .snap_vld  (ir_vld)
    );

    always_ff @(posedge CLK_IP or negedge RSTN_IP) begin
        if (!RSTN_IP) begin
            state   <= IDLE;
            ack     <= 1'b0;
            rdata   <= '0;
            err     <= 1'b0;
            inhibit <= INHIBIT_RST & 3'b101;
        end else begin
            unique case (state)
                IDLE: begin
                    if (csr.CSR_REQ_IP) begin
                        state <= RESP;
                        ack   <= 1'b1;
                        rdata <= rd_val;
                        err   <= err_c;
                        if (inh_wr) begin
                            inhibit <= {csr.CSR_WDATA_IP[INH_IR], 1'b0,
                                        csr.CSR_WDATA_IP[INH_CY]};
                        end
                    end
                end
                RESP: begin
                    state <= IDLE;
                    ack   <= 1'b0;
                    rdata <= '0;
                    err   <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign csr.CSR_ACK_OP   = ack;
    assign csr.CSR_RDATA_OP = rdata;
    assign csr.CSR_ERR_OP   = err;

endmodule

// File: tb/tb_counter_csr_ctrl.sv
// Directed bench for counter_csr_ctrl with a response scoreboard.
// Each access spans two clocks: accept edge, then the RESP edge.
module tb_counter_csr_ctrl;

    typedef struct packed {
        logic [31:0] rd;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic retire = 1'b0;
    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    counter_csr_ctrl_if bus ();

    counter_csr_ctrl #(
        .INHIBIT_RST (3'b000),
        .SNAPSHOT_EN (1'b1)
    ) dut (
        .CLK_IP    (clk),
        .RSTN_IP   (rst_n),
        .RETIRE_IP (retire),
        .csr       (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic acc(input string tag, input logic we,
                       input logic [11:0] addr, input logic [31:0] wd,
                       input logic [31:0] erd, input logic eerr);
        exp_t e;
        int   n;
        sb.push_back('{rd: erd, err: eerr});
        bus.CSR_REQ_IP   = 1'b1;
        bus.CSR_WE_IP    = we;
        bus.CSR_ADDR_IP  = addr;
        bus.CSR_WDATA_IP = wd;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.CSR_ACK_OP !== 1'b1 && n < 4);
        chk({tag, "_lat"}, 64'(n), 64'd1);
        e = sb.pop_front();
        if (bus.CSR_ACK_OP === 1'b1) begin
            chk({tag, "_rd"}, 64'(bus.CSR_RDATA_OP), 64'(e.rd));
            chk({tag, "_err"}, 64'(bus.CSR_ERR_OP), 64'(e.err));
        end else begin
            chk({tag, "_ack"}, 64'(bus.CSR_ACK_OP), 64'd1);
        end
        bus.CSR_REQ_IP = 1'b0;
        bus.CSR_WE_IP  = 1'b0;
        @(negedge clk);
        chk({tag, "_ackdrop"}, 64'(bus.CSR_ACK_OP), 64'd0);
    endtask

    initial begin
        bus.CSR_REQ_IP   = 1'b0;
        bus.CSR_WE_IP    = 1'b0;
        bus.CSR_ADDR_IP  = '0;
        bus.CSR_WDATA_IP = '0;

        repeat (3) @(negedge clk);
        chk("rst_ack", 64'(bus.CSR_ACK_OP), 64'd0);
        chk("rst_rdata", 64'(bus.CSR_RDATA_OP), 64'd0);
        chk("rst_err", 64'(bus.CSR_ERR_OP), 64'd0);
        rst_n = 1'b1;

        // 10 counting edges, read accepted on the 11th
        repeat (10) @(posedge clk);
        @(negedge clk);
        acc("cycle10", 1'b0, 12'hC00, 32'h0, 32'd10, 1'b0);

        // low-half carry, snapshot of the pre-carry high half, then live
        acc("wr_lo", 1'b1, 12'hB00, 32'hFFFF_FFFE, 32'h0, 1'b0);
        acc("rd_lo_max", 1'b0, 12'hB00, 32'h0, 32'hFFFF_FFFF, 1'b0);
        acc("rd_hi_snap0", 1'b0, 12'hB80, 32'h0, 32'd0, 1'b0);
        acc("rd_hi_live1", 1'b0, 12'hB80, 32'h0, 32'd1, 1'b0);

        // preload 0x1_FFFFFFFE, one increment before the low read
        acc("wr_hi1", 1'b1, 12'hB80, 32'd1, 32'h0, 1'b0);
        acc("wr_lo_fe", 1'b1, 12'hB00, 32'hFFFF_FFFE, 32'h0, 1'b0);
        acc("rd_c00", 1'b0, 12'hC00, 32'h0, 32'hFFFF_FFFF, 1'b0);
        repeat (5) @(negedge clk);
        acc("rd_c80_snap", 1'b0, 12'hC80, 32'h0, 32'd1, 1'b0);
        acc("rd_c80_live", 1'b0, 12'hC80, 32'h0, 32'd2, 1'b0);

        // inhibit write: the write edge still counts with the old value
        acc("wr_cy100", 1'b1, 12'hB00, 32'd100, 32'h0, 1'b0);
        acc("wr_inh5", 1'b1, 12'h320, 32'd5, 32'h0, 1'b0);
        acc("rd_inh5", 1'b0, 12'h320, 32'h0, 32'd5, 1'b0);
        for (int i = 0; i < 4; i++) begin
            retire = 1'b1;
            @(negedge clk);
            retire = 1'b0;
            @(negedge clk);
        end
        repeat (20) @(negedge clk);
        acc("frozen_cy", 1'b0, 12'hC00, 32'h0, 32'd102, 1'b0);
        acc("frozen_ir", 1'b0, 12'hC02, 32'h0, 32'd0, 1'b0);
        acc("wr_inh0", 1'b1, 12'h320, 32'd0, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            retire = 1'b1;
            @(negedge clk);
        end
        retire = 1'b0;
        acc("resume_cy", 1'b0, 12'hC00, 32'h0, 32'd106, 1'b0);
        acc("resume_ir", 1'b0, 12'hC02, 32'h0, 32'd3, 1'b0);

        // error paths leave state alone
        acc("wr_ro", 1'b1, 12'hC02, 32'hDEAD, 32'h0, 1'b1);
        acc("rd_bad", 1'b0, 12'h7FF, 32'h0, 32'h0, 1'b1);
        acc("ir_kept", 1'b0, 12'hB02, 32'h0, 32'd3, 1'b0);
        acc("inh_kept", 1'b0, 12'h320, 32'h0, 32'd0, 1'b0);

        // request held through RESP is re-accepted only from IDLE
        bus.CSR_REQ_IP  = 1'b1;
        bus.CSR_WE_IP   = 1'b0;
        bus.CSR_ADDR_IP = 12'hC02;
        @(negedge clk);
        chk("held_ack1", 64'(bus.CSR_ACK_OP), 64'd1);
        chk("held_rd1", 64'(bus.CSR_RDATA_OP), 64'd3);
        @(negedge clk);
        chk("held_gap", 64'(bus.CSR_ACK_OP), 64'd0);
        @(negedge clk);
        chk("held_ack2", 64'(bus.CSR_ACK_OP), 64'd1);
        chk("held_rd2", 64'(bus.CSR_RDATA_OP), 64'd3);
        bus.CSR_REQ_IP = 1'b0;
        @(negedge clk);
        chk("held_end", 64'(bus.CSR_ACK_OP), 64'd0);

        // reset during RESP
        acc("wr_hi0", 1'b1, 12'hB80, 32'd0, 32'h0, 1'b0);
        acc("wr_1233", 1'b1, 12'hB00, 32'h1233, 32'h0, 1'b0);
        bus.CSR_REQ_IP  = 1'b1;
        bus.CSR_ADDR_IP = 12'hC00;
        @(posedge clk);
        #1;
        chk("pre_rst_ack", 64'(bus.CSR_ACK_OP), 64'd1);
        chk("pre_rst_rd", 64'(bus.CSR_RDATA_OP), 64'h1234);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ack", 64'(bus.CSR_ACK_OP), 64'd0);
        chk("mid_rst_rd", 64'(bus.CSR_RDATA_OP), 64'd0);
        chk("mid_rst_err", 64'(bus.CSR_ERR_OP), 64'd0);
        @(negedge clk);
        bus.CSR_REQ_IP = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("post_rst_noack", 64'(bus.CSR_ACK_OP), 64'd0);
        end
        acc("post_rst_cy", 1'b0, 12'hC00, 32'h0, 32'd2, 1'b0);
        acc("post_rst_inh", 1'b0, 12'h320, 32'h0, 32'd0, 1'b0);
        acc("post_rst_ir", 1'b0, 12'hB02, 32'h0, 32'd0, 1'b0);
        acc("post_rst_hi", 1'b0, 12'hB80, 32'h0, 32'd0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/counter_csr_ctrl.md
Name: counter_csr_ctrl

Overview:
- CSR-side controller for the core's performance counters: owns the 64-bit cycle and instret counters, the inhibit register, and the 32-bit CSR access path the pipeline uses to read and write them.
- Sits between the CSR stage of the pipeline and the counter storage.
- Sequences increments against software writes.
- Provides a tear-free low/high read of each 64-bit counter.

Parameters:
- INHIBIT_RST, 3'b000: reset value of mcountinhibit (bit0 = CY, bit2 = IR; bit1 is hardwired 0).
- SNAPSHOT_EN, 1: 1 enables the high-half snapshot on a low-half read; 0 makes high reads always live.

Ports:
- CLK_IP  in  1  single clock.
- RSTN_IP  in  1  asynchronous, active-low reset.
- RETIRE_IP  in  1  one-cycle pulse per retired instruction.
- CSR_REQ_IP  in  1  access request; held high until CSR_ACK_OP.
- CSR_WE_IP  in  1  1 = write, 0 = read; stable while REQ is high.
- CSR_ADDR_IP  in  12  CSR address; stable while REQ is high.
- CSR_WDATA_IP  in  32  write data.
- CSR_ACK_OP  out  1  one-cycle response strobe.
- CSR_RDATA_OP  out  32  read data; valid when ACK is high, 0 otherwise.
- CSR_ERR_OP  out  1  valid with ACK; illegal address, or write to a read-only address.

Behaviour:
- Reset (async, RSTN_IP low):
  - cycle = 0, instret = 0, inhibit = INHIBIT_RST.
  - Both snapshots = 0, both snapshot-valid flags = 0.
  - FSM = IDLE; ACK = 0, RDATA = 0, ERR = 0.
  - Reset mid-access drops the access silently; no ACK is issued.
- Counting, every clock:
  - cycle += 1 unless inhibit[0].
  - instret += 1 when RETIRE_IP is high and inhibit[2] is 0.
  - Both counters are 64-bit and wrap from 2^64-1 to 0 with no flag.
- FSM IDLE -> RESP:
  - Taken when CSR_REQ_IP is high in IDLE. The request is accepted on that edge.
  - Read data, ERR and any write effect are all applied on that same edge.
- FSM RESP -> IDLE:
  - Unconditional. ACK is high for exactly this one cycle.
  - Latency is one cycle from accept to ACK.
  - A request is never accepted while in RESP, so maximum throughput is one access per 2 cycles.
- Address map:
  - mcycle 0xB00 / mcycleh 0xB80: read/write.
  - minstret 0xB02 / minstreth 0xB82: read/write.
  - cycle 0xC00 / cycleh 0xC80 and instret 0xC02 / instreth 0xC82: read-only aliases of the same counters.
  - mcountinhibit 0x320: read/write, bits [2:0] only; upper bits read 0.
  - Any other address: ERR = 1, RDATA = 0, no state change.
- Writes:
  - A write to a read-only address gives ERR = 1 and changes nothing; RDATA = 0.
  - A write to a low half replaces bits [31:0] and keeps [63:32]; a write to a high half does the reverse.
  - Write wins over increment: the written counter does not increment on the write edge. The other counter counts normally.
  - Any write to a counter clears that counter's snapshot-valid flag.
  - Writing mcountinhibit takes effect from the next edge. The increment on the write edge uses the old inhibit value.
- Snapshot (SNAPSHOT_EN = 1):
  - A read of a counter's low half (either alias) returns the pre-increment value [31:0].
  - The same read loads that counter's snapshot with [63:32] and sets its valid flag.
  - A following high-half read returns the snapshot if valid, then clears the flag. If not valid, it returns the live [63:32].
  - The cycle and instret snapshots are independent.
- Read values are pre-increment values sampled at the accept edge.

Decomposition:
- Shared package counter_csr_pkg holds:
  - the 12-bit CSR address constants listed above;
  - the inhibit bit indices (CY = 0, IR = 2);
  - the FSM state enum {IDLE, RESP}.
- One sub-module, counter64_unit, is instantiated twice (cycle and instret). It contains:
  - the 64-bit register, inc_en, and lo/hi write-enables with data;
  - the snapshot register with its valid flag, plus snap_load and snap_clr controls;
  - write-over-increment priority implemented locally.
- The top level holds the FSM, address decode, the inhibit register and the read mux.

Test Plan:
- Reset release, inhibit = 0, 10 idle cycles, then read 0xC00 -> ACK one cycle after accept, RDATA = 10, ERR = 0.
- Write 0xB00 = 0xFFFFFFFE, then read 0xB00 at the next accept -> the read returns 0xFFFFFFFF or later; a following 0xB80 read returns 1 once the low half has carried.
- Preload cycle = 0x00000001_FFFFFFFF and read 0xC00 -> RDATA = 0xFFFFFFFF. Then read 0xC80 several cycles later -> RDATA = 1 (snapshot), although the live high half is now 2. A second 0xC80 read returns the live value 2.
- Write 0x320 = 5, then pulse RETIRE_IP 4 times and wait 20 cycles -> cycle and instret are unchanged. Write 0x320 = 0, then 3 retire pulses -> instret += 3.
- Write to 0xC02, and a read of 0x7FF -> both give ERR = 1, RDATA = 0, all counters unaffected. A request held high during RESP is accepted only on the following IDLE cycle.
- Deassert RSTN_IP mid-RESP with cycle = 0x1234 -> ACK = 0 immediately, all counters and FSM at reset values, no stale ACK after release.
